// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: coin-operated vending controller with parametrised price,
// cancel/refund path, per-press edge detection and a credit readout.
// Latency: a press is taken on a sample tick and credit updates on that
// edge. dispense/collect follow one clk after the credit reaches PRICE.
// Change and refund come out as one half_out pulse per following tick.
// Backpressure: none. Presses seen while busy, and lower-priority presses
// on the same tick, are dropped.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   half_dollar         half-dollar coin button (active-low, debounced)
//   one_dollar          one-dollar coin button (active-low, debounced)
//   cancel              refund button (active-low, debounced)
//   dispense, collect   1-clk pulses when an item is vended
//   half_out            1-clk pulse per half-dollar of change or refund
//   busy                high while vending or paying out
//   credit              accumulated credit in half-dollar units
module vend_ctrl_param #(
  parameter int CLK_DIV  = 50000000,
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                half_dollar,
  input  logic                one_dollar,
  input  logic                cancel,
  output logic                dispense,
  output logic                collect,
  output logic                half_out,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  // Reject parameter sets the datapath cannot represent.
  if ((PRICE < 1) || (PRICE > (2 ** CREDIT_W) - 2)) begin : g_bad_price
    $error("vend_ctrl_param: PRICE must be in 1..2^CREDIT_W-2");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vend_ctrl_param: CLK_DIV must be at least 2");
  end

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_VEND    = 2'd1;
  localparam logic [1:0] S_CHANGE  = 2'd2;
  localparam logic [1:0] S_REFUND  = 2'd3;

  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  logic                prev_half;
  logic                prev_one;
  logic                prev_cancel;
  logic                press_half;
  logic                press_one;
  logic                press_cancel;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W-1:0] change_q;
  logic [CREDIT_W-1:0] change_d;
  logic                dispense_q;
  logic                dispense_d;
  logic                collect_q;
  logic                collect_d;
  logic                half_out_q;
  logic                half_out_d;
  logic                busy_q;

  // Sample tick: one clk in every CLK_DIV.
  assign tick = (tick_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Buttons are active-low: a press is a 1->0 change between two ticks.
  assign press_half   = tick & prev_half   & ~half_dollar;
  assign press_one    = tick & prev_one    & ~one_dollar;
  assign press_cancel = tick & prev_cancel & ~cancel;

  // Previous samples track the buttons on every tick, busy or not, so a
  // button held through a vend or refund is not counted when it ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_half   <= 1'b1;
      prev_one    <= 1'b1;
      prev_cancel <= 1'b1;
    end else if (tick) begin
      prev_half   <= half_dollar;
      prev_one    <= one_dollar;
      prev_cancel <= cancel;
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    dispense_d = 1'b0;
    collect_d  = 1'b0;
    half_out_d = 1'b0;
    case (state_q)
      S_COLLECT: begin
        // cancel > one_dollar > half_dollar; a cancel with no credit
        // still uses up the tick.
        if (press_cancel) begin
          if (credit_q != '0) begin
            change_d = credit_q;
            credit_d = '0;
            state_d  = S_REFUND;
          end
        end else if (press_one || press_half) begin
          credit_d = credit_q + (press_one ? CREDIT_W'(2) : CREDIT_W'(1));
          if (credit_d >= PRICE_C) begin
            state_d = S_VEND;
          end
        end
      end
      S_VEND: begin
        dispense_d = 1'b1;
        collect_d  = 1'b1;
        // Overpay is at most one half-dollar (a dollar on PRICE-1).
        change_d   = credit_q - PRICE_C;
        credit_d   = '0;
        state_d    = (credit_q > PRICE_C) ? S_CHANGE : S_COLLECT;
      end
      S_CHANGE, S_REFUND: begin
        if (tick) begin
          if (change_q != '0) begin
            half_out_d = 1'b1;
            change_d   = change_q - CREDIT_W'(1);
            if (change_q == CREDIT_W'(1)) begin
              state_d = S_COLLECT;
            end
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_COLLECT;
      credit_q   <= '0;
      change_q   <= '0;
      dispense_q <= 1'b0;
      collect_q  <= 1'b0;
      half_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      dispense_q <= dispense_d;
      collect_q  <= collect_d;
      half_out_q <= half_out_d;
      // Registered alongside the state so busy tracks it exactly.
      busy_q     <= (state_d != S_COLLECT);
    end
  end

  assign dispense = dispense_q;
  assign collect  = collect_q;
  assign half_out = half_out_q;
  assign busy     = busy_q;
  assign credit   = credit_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: table-driven checks of vend_ctrl_param with CLK_DIV=4,
// PRICE=5, CREDIT_W=3, plus a hand-written reset-in-CHANGE sequence.
// Each table row is held for one sample tick; pulses are counted over the
// clks leading up to and including that tick.
module tb_vend_ctrl_param;

  localparam int CLK_DIV  = 4;
  localparam int PRICE    = 5;
  localparam int CREDIT_W = 3;
  localparam int NROWS    = 36;

  logic                clk;
  logic                reset;
  logic                half_dollar;
  logic                one_dollar;
  logic                cancel;
  logic                dispense;
  logic                collect;
  logic                half_out;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  vend_ctrl_param #(
    .CLK_DIV  (CLK_DIV),
    .PRICE    (PRICE),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .half_dollar (half_dollar),
    .one_dollar  (one_dollar),
    .cancel      (cancel),
    .dispense    (dispense),
    .collect     (collect),
    .half_out    (half_out),
    .busy        (busy),
    .credit      (credit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic h;
    logic o;
    logic c;
    int   exp_credit;
    logic exp_busy;
    int   exp_nd;
    int   exp_nc;
    int   exp_nh;
  } vec_t;

  vec_t tbl [NROWS];
  int   nchk;
  int   nerr;
  int   ncyc;
  logic last_d;
  logic last_c;
  logic last_h;

  function automatic vec_t mk(input logic h, input logic o, input logic c,
                              input int cr, input logic b,
                              input int nd, input int nc, input int nh);
    vec_t v;
    v.h = h; v.o = o; v.c = c;
    v.exp_credit = cr; v.exp_busy = b;
    v.exp_nd = nd; v.exp_nc = nc; v.exp_nh = nh;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clk; outputs are looked at 1 time unit after the rising edge.
  task automatic clk1();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // Hold the row's button levels until the next tick edge has passed.
  task automatic do_row(input string tag, input vec_t v);
    int nd, nc, nh, dbl;
    nd = 0; nc = 0; nh = 0; dbl = 0;
    half_dollar = v.h;
    one_dollar  = v.o;
    cancel      = v.c;
    do begin
      clk1();
      if (dispense) nd++;
      if (collect)  nc++;
      if (half_out) nh++;
      if (dispense != collect) dbl++;
      if ((dispense && last_d) || (collect && last_c) || (half_out && last_h)) dbl++;
      last_d = dispense;
      last_c = collect;
      last_h = half_out;
    end while (ncyc % CLK_DIV != 0);
    check({tag, " credit"},   int'(credit),   v.exp_credit);
    check({tag, " busy"},     int'(busy),     int'(v.exp_busy));
    check({tag, " dispense"}, nd,             v.exp_nd);
    check({tag, " collect"},  nc,             v.exp_nc);
    check({tag, " half_out"}, nh,             v.exp_nh);
    check({tag, " pulse_shape"}, dbl,         0);
  endtask

  initial begin
    int nh;
    nchk = 0; nerr = 0; ncyc = 0;
    last_d = 1'b0; last_c = 1'b0; last_h = 1'b0;

    //              h  o  c  credit busy nd nc nh
    // 1: five half presses -> vend, no change
    tbl[0]  = mk(0, 1, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 2, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 2, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 3, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 3, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 4, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 4, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 5, 1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 1, 0, 0, 1, 1, 0);
    // 2: three one presses -> credit 6, vend, one half of change
    tbl[10] = mk(1, 0, 1, 2, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 1, 2, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 1, 4, 0, 0, 0, 0);
    tbl[13] = mk(1, 1, 1, 4, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 1, 6, 1, 0, 0, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, 1, 1, 1);
    tbl[16] = mk(1, 1, 1, 0, 0, 0, 0, 0);
    // 3: half, one, cancel -> refund of 3 on three ticks
    tbl[17] = mk(0, 1, 1, 1, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 1, 3, 0, 0, 0, 0);
    tbl[19] = mk(1, 1, 0, 0, 1, 0, 0, 0);
    tbl[20] = mk(1, 1, 1, 0, 1, 0, 0, 1);
    tbl[21] = mk(1, 1, 1, 0, 1, 0, 0, 1);
    tbl[22] = mk(1, 1, 1, 0, 0, 0, 0, 1);
    tbl[23] = mk(1, 1, 1, 0, 0, 0, 0, 0);
    // 4: half held across three ticks counts once
    tbl[24] = mk(0, 1, 1, 1, 0, 0, 0, 0);
    tbl[25] = mk(0, 1, 1, 1, 0, 0, 0, 0);
    tbl[26] = mk(0, 1, 1, 1, 0, 0, 0, 0);
    tbl[27] = mk(1, 1, 1, 1, 0, 0, 0, 0);
    // clear with a refund of 1
    tbl[28] = mk(1, 1, 0, 0, 1, 0, 0, 0);
    tbl[29] = mk(1, 1, 1, 0, 0, 0, 0, 1);
    // 5: half+one on one tick -> 2; cancel+one -> refund 2, coin dropped;
    //    a half press during the refund is dropped too
    tbl[30] = mk(0, 0, 1, 2, 0, 0, 0, 0);
    tbl[31] = mk(1, 1, 1, 2, 0, 0, 0, 0);
    tbl[32] = mk(1, 0, 0, 0, 1, 0, 0, 0);
    tbl[33] = mk(0, 1, 1, 0, 1, 0, 0, 1);
    tbl[34] = mk(1, 1, 1, 0, 0, 0, 0, 1);
    tbl[35] = mk(1, 1, 1, 0, 0, 0, 0, 0);

    half_dollar = 1'b1;
    one_dollar  = 1'b1;
    cancel      = 1'b1;
    reset       = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("reset credit",   int'(credit),   0);
    check("reset busy",     int'(busy),     0);
    check("reset dispense", int'(dispense), 0);
    check("reset collect",  int'(collect),  0);
    check("reset half_out", int'(half_out), 0);
    clk1();
    clk1();
    reset = 1'b1;
    ncyc  = 0;

    for (int i = 0; i < NROWS; i++) begin
      do_row($sformatf("row%0d", i), tbl[i]);
    end

    // 6: reset in CHANGE (change=1) at tick count 2.
    do_row("t6a", mk(1, 0, 1, 2, 0, 0, 0, 0));
    do_row("t6b", mk(1, 1, 1, 2, 0, 0, 0, 0));
    do_row("t6c", mk(1, 0, 1, 4, 0, 0, 0, 0));
    do_row("t6d", mk(1, 1, 1, 4, 0, 0, 0, 0));
    do_row("t6e", mk(1, 0, 1, 6, 1, 0, 0, 0));
    one_dollar = 1'b1;
    clk1();
    check("t6 vend dispense", int'(dispense), 1);
    check("t6 vend collect",  int'(collect),  1);
    clk1();
    check("t6 change busy",   int'(busy),     1);
    check("t6 change credit", int'(credit),   0);
    reset       = 1'b0;
    half_dollar = 1'b0;
    #1;
    check("t6 rst busy",     int'(busy),     0);
    check("t6 rst dispense", int'(dispense), 0);
    check("t6 rst collect",  int'(collect),  0);
    check("t6 rst half_out", int'(half_out), 0);
    check("t6 rst credit",   int'(credit),   0);
    clk1();
    clk1();
    reset = 1'b1;
    ncyc  = 0;
    nh    = 0;
    // A held-low half button is a press on the first tick after reset,
    // which must land on the CLK_DIV-th edge.
    for (int n = 1; n <= 2 * CLK_DIV; n++) begin
      clk1();
      if (half_out) nh++;
      if (n == CLK_DIV - 1) check("t6 pre-tick credit", int'(credit), 0);
      if (n == CLK_DIV)     check("t6 first tick credit", int'(credit), 1);
    end
    check("t6 no stale half_out", nh, 0);
    check("t6 final busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
